// File: rtl/alu_issue_ctrl_if.sv
// Issue and writeback channels of the ALU issue controller, grouped as one bundle.
// master = requester/consumer side, slave = alu_issue_ctrl side.
interface alu_issue_ctrl_if #(
  parameter int W    = 16,
  parameter int OPW  = 8,
  parameter int DSTW = 4
);
  logic            issue_valid;
  logic            issue_ready;
  logic [OPW-1:0]  issue_op;
  logic [W-1:0]    issue_a;
  logic [W-1:0]    issue_b;
  logic [DSTW-1:0] issue_dst;
  logic            issue_use_cf;
  logic            issue_flag_we;

  logic            wb_valid;
  logic            wb_ready;
  logic [W-1:0]    wb_acc;
  logic [W-1:0]    wb_c;
  logic [DSTW-1:0] wb_dst;

  modport master (
    output issue_valid, issue_op, issue_a, issue_b, issue_dst,
           issue_use_cf, issue_flag_we, wb_ready,
    input  issue_ready, wb_valid, wb_acc, wb_c, wb_dst
  );

  modport slave (
    input  issue_valid, issue_op, issue_a, issue_b, issue_dst,
           issue_use_cf, issue_flag_we, wb_ready,
    output issue_ready, wb_valid, wb_acc, wb_c, wb_dst
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-op issue control for a clocked ALU: accept, hold operands ALU_LAT edges, capture, write back.
// Issue-to-capture is ALU_LAT+1 edges; issue_ready is low until the result leaves through wb_valid/wb_ready.
module alu_issue_ctrl #(
  parameter int W       = 16,
  parameter int OPW     = 8,
  parameter int ALU_LAT = 1,
  parameter int DSTW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_ctrl_if.slave bus,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic [OPW-1:0]  alu_op,
  output logic            alu_cf,
  input  logic [W-1:0]    alu_acc,
  input  logic [W-1:0]    alu_c,
  input  logic            alu_c_flag,
  input  logic            alu_z_flag,
  input  logic            alu_o_flag,
  output logic [2:0]      flags,
  output logic            busy
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [DSTW-1:0] dst_q;
  logic            flag_we_q;
  logic [W-1:0]    wb_acc_q;
  logic [W-1:0]    wb_c_q;
  logic [DSTW-1:0] wb_dst_q;
  logic [2:0]      flags_q;

  logic accept;
  logic capture;

  assign accept  = (state_q == IDLE) && bus.issue_valid;
  assign capture = (state_q == EXEC) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.issue_valid) state_d = EXEC;
      EXEC:    if (cnt_q == '0)     state_d = WB;
      WB:      if (bus.wb_ready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dst_q     <= '0;
      flag_we_q <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cf    <= 1'b0;
      wb_acc_q  <= '0;
      wb_c_q    <= '0;
      wb_dst_q  <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a     <= bus.issue_a;
        alu_b     <= bus.issue_b;
        alu_op    <= bus.issue_op;
        // Carry-in uses the flags as they stand before this op can change them.
        alu_cf    <= bus.issue_use_cf & flags_q[2];
        dst_q     <= bus.issue_dst;
        flag_we_q <= bus.issue_flag_we;
        cnt_q     <= CNT_INIT;
      end else if (capture) begin
        wb_acc_q <= alu_acc;
        wb_c_q   <= alu_c;
        wb_dst_q <= dst_q;
        if (flag_we_q) flags_q <= {alu_c_flag, alu_o_flag, alu_z_flag};
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign bus.issue_ready = (state_q == IDLE);
  assign bus.wb_valid    = (state_q == WB);
  assign bus.wb_acc      = wb_acc_q;
  assign bus.wb_c        = wb_c_q;
  assign bus.wb_dst      = wb_dst_q;
  assign flags           = flags_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench: one controller with ALU_LAT=1, one with ALU_LAT=3, each driving a behavioural ALU.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] c;
    logic        cf;
    logic        of;
    logic        zf;
  } alu_res_t;

  typedef struct packed {
    logic [15:0] acc;
    logic [15:0] c;
    logic [3:0]  dst;
    logic [2:0]  fl;
    logic        fwe;
  } exp_t;

  function automatic alu_res_t alu_model(input logic [7:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    alu_res_t r;
    logic [31:0] p;
    r = '0;
    case (op)
      8'h02: begin
        {r.cf, r.acc} = {1'b0, a} + {1'b0, b} + {16'h0, cin};
        r.of = (a[15] == b[15]) && (r.acc[15] != a[15]);
      end
      8'h03: begin
        p = a * b;
        r.acc = p[15:0];
        r.c   = p[31:16];
        r.cf  = |p[31:16];
      end
      default: r = '0;
    endcase
    r.zf = (r.acc == 16'h0);
    return r;
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv, wr, iuc, ifwe;
  logic [7:0] iop;
  logic [15:0] ia, ib;
  logic [3:0] idst;
  bit sel;

  alu_issue_ctrl_if #(.W(16), .OPW(8), .DSTW(4)) b1 ();
  alu_issue_ctrl_if #(.W(16), .OPW(8), .DSTW(4)) b3 ();

  assign b1.issue_valid = iv & !sel;   assign b3.issue_valid = iv & sel;
  assign b1.wb_ready    = wr & !sel;   assign b3.wb_ready    = wr & sel;
  assign b1.issue_op = iop;   assign b3.issue_op = iop;
  assign b1.issue_a  = ia;    assign b3.issue_a  = ia;
  assign b1.issue_b  = ib;    assign b3.issue_b  = ib;
  assign b1.issue_dst = idst; assign b3.issue_dst = idst;
  assign b1.issue_use_cf = iuc;   assign b3.issue_use_cf = iuc;
  assign b1.issue_flag_we = ifwe; assign b3.issue_flag_we = ifwe;

  logic [15:0] a1_a, a1_b, a3_a, a3_b;
  logic [7:0]  a1_op, a3_op;
  logic        a1_cf, a3_cf, busy1, busy3;
  logic [2:0]  fl1, fl3;
  alu_res_t    r1, r3;
  assign r1 = alu_model(a1_op, a1_a, a1_b, a1_cf);
  assign r3 = alu_model(a3_op, a3_a, a3_b, a3_cf);

  alu_issue_ctrl #(.W(16), .OPW(8), .ALU_LAT(1), .DSTW(4)) dut1 (
    .clk(clk), .rst(rst), .bus(b1),
    .alu_a(a1_a), .alu_b(a1_b), .alu_op(a1_op), .alu_cf(a1_cf),
    .alu_acc(r1.acc), .alu_c(r1.c), .alu_c_flag(r1.cf), .alu_z_flag(r1.zf), .alu_o_flag(r1.of),
    .flags(fl1), .busy(busy1)
  );

  alu_issue_ctrl #(.W(16), .OPW(8), .ALU_LAT(3), .DSTW(4)) dut3 (
    .clk(clk), .rst(rst), .bus(b3),
    .alu_a(a3_a), .alu_b(a3_b), .alu_op(a3_op), .alu_cf(a3_cf),
    .alu_acc(r3.acc), .alu_c(r3.c), .alu_c_flag(r3.cf), .alu_z_flag(r3.zf), .alu_o_flag(r3.of),
    .flags(fl3), .busy(busy3)
  );

  // Outputs of whichever controller is currently selected.
  wire        m_ready = sel ? b3.issue_ready : b1.issue_ready;
  wire        m_wbv   = sel ? b3.wb_valid : b1.wb_valid;
  wire [15:0] m_acc   = sel ? b3.wb_acc : b1.wb_acc;
  wire [15:0] m_c     = sel ? b3.wb_c : b1.wb_c;
  wire [3:0]  m_dst   = sel ? b3.wb_dst : b1.wb_dst;
  wire [15:0] m_aa    = sel ? a3_a : a1_a;
  wire [15:0] m_ab    = sel ? a3_b : a1_b;
  wire [7:0]  m_aop   = sel ? a3_op : a1_op;
  wire        m_acf   = sel ? a3_cf : a1_cf;
  wire [2:0]  m_fl    = sel ? fl3 : fl1;
  wire        m_busy  = sel ? busy3 : busy1;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [2:0] exp_flags [2];
  logic last_cf;
  logic [15:0] last_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] dst, input logic uc, input logic fwe);
    alu_res_t r;
    exp_t e;
    last_cf = uc & exp_flags[sel][2];
    last_a  = a;
    r = alu_model(op, a, b, last_cf);
    e.acc = r.acc; e.c = r.c; e.dst = dst; e.fl = {r.cf, r.of, r.zf}; e.fwe = fwe;
    q.push_back(e);
    iop = op; ia = a; ib = b; idst = dst; iuc = uc; ifwe = fwe; iv = 1'b1;
  endtask

  task automatic wait_accept(output int n);
    bit took;
    n = 0;
    took = 1'b0;
    while (!took && n < 30) begin
      took = m_ready;
      @(posedge clk); #1;
      n++;
    end
    iv = 1'b0;
    chk("accept_seen", {31'd0, took}, 32'd1);
    chk("alu_cf", {31'd0, m_acf}, {31'd0, last_cf});
    chk("alu_a", {16'd0, m_aa}, {16'd0, last_a});
    chk("busy_exec", {31'd0, m_busy}, 32'd1);
  endtask

  task automatic wait_wb(input int lat);
    int n = 0;
    while (!m_wbv && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wb_latency", n, lat);
  endtask

  task automatic retire();
    exp_t e;
    chk("wb_valid_up", {31'd0, m_wbv}, 32'd1);
    chk("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.fwe) exp_flags[sel] = e.fl;
      chk("wb_acc", {16'd0, m_acc}, {16'd0, e.acc});
      chk("wb_c", {16'd0, m_c}, {16'd0, e.c});
      chk("wb_dst", {28'd0, m_dst}, {28'd0, e.dst});
      chk("flags", {29'd0, m_fl}, {29'd0, exp_flags[sel]});
    end
    wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    chk("wb_valid_down", {31'd0, m_wbv}, 32'd0);
    chk("ready_after_wb", {31'd0, m_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] dst, input logic uc, input logic fwe, input int lat);
    int n;
    drive_issue(op, a, b, dst, uc, fwe);
    wait_accept(n);
    wait_wb(lat);
    retire();
  endtask

  initial begin
    int n;
    bit seen;
    iv = 0; wr = 0; iuc = 0; ifwe = 0; iop = '0; ia = '0; ib = '0; idst = '0; sel = 0;
    exp_flags[0] = 3'b000;
    exp_flags[1] = 3'b000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, m_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, m_wbv}, 32'd0);
    chk("rst_busy", {31'd0, m_busy}, 32'd0);
    chk("rst_flags", {29'd0, m_fl}, 32'd0);
    chk("rst_alu", {m_aa, m_ab}, 32'd0);
    chk("rst_alu_op_cf", {23'd0, m_aop, m_acf}, 32'd0);
    chk("rst_wb", {m_acc, m_c}, 32'd0);
    chk("rst_wb_dst", {28'd0, m_dst}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold_busy", {31'd0, m_busy}, 32'd0);
    chk("idle_hold_ready", {31'd0, m_ready}, 32'd1);

    // single add, ALU_LAT=1
    run_op(8'h02, 16'd10, 16'd11, 4'd3, 1'b0, 1'b1, 1);

    // carry chain: set C, then consume it
    run_op(8'h02, 16'hFFFF, 16'h0001, 4'd5, 1'b0, 1'b1, 1);
    chk("flags_101", {29'd0, m_fl}, 32'd5);
    run_op(8'h02, 16'd5, 16'd6, 4'd1, 1'b1, 1'b1, 1);

    // backpressure on writeback with a pending issue
    drive_issue(8'h03, 16'h1234, 16'h0100, 4'd6, 1'b0, 1'b1);
    wait_accept(n);
    wait_wb(1);
    drive_issue(8'h02, 16'd1, 16'd2, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_wb_valid", {31'd0, m_wbv}, 32'd1);
      chk("bp_wb_acc", {16'd0, m_acc}, 32'h3400);
      chk("bp_ready", {31'd0, m_ready}, 32'd0);
      chk("bp_alu_a", {16'd0, m_aa}, 32'h1234);
    end
    retire();
    wait_accept(n);
    chk("bp_accept_edges", n, 1);
    wait_wb(1);
    retire();

    // flag_we=0 leaves flags alone (expected 100 from the multiply)
    run_op(8'h02, 16'hFFFF, 16'h0001, 4'd8, 1'b0, 1'b0, 1);
    chk("flags_kept", {29'd0, m_fl}, 32'd4);

    // ALU_LAT=3 controller
    sel = 1;
    run_op(8'h02, 16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b1, 3);
    chk("lat3_flags", {29'd0, m_fl}, 32'd5);

    // reset one cycle after accept
    drive_issue(8'h02, 16'd3, 16'd4, 4'd2, 1'b1, 1'b1);
    wait_accept(n);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_wb_valid", {31'd0, m_wbv}, 32'd0);
    chk("mid_rst_flags", {29'd0, m_fl}, 32'd0);
    chk("mid_rst_ready", {31'd0, m_ready}, 32'd1);
    chk("mid_rst_alu_a", {16'd0, m_aa}, 32'd0);
    q.delete();
    exp_flags[0] = 3'b000;
    exp_flags[1] = 3'b000;
    #2;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (m_wbv) seen = 1'b1;
    end
    chk("mid_rst_no_wb", {31'd0, seen}, 32'd0);
    chk("mid_rst_flags_after", {29'd0, m_fl}, 32'd0);
    chk("mid_rst_ready_after", {31'd0, m_ready}, 32'd1);

    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
